display_scheduler: RTL and testbench



---
 rtl/display_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_display_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// display_scheduler
// Time-shares one 8-digit seven-segment display between N requesters.
// Round-robin arbitration with a programmable dwell (in en ticks), optional
// blank gap between different owners, urgent preemption and a pin hold.
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   en               one-clk timing strobe; dwell and blank count in en ticks
//   req[N]           level request per requester
//   urgent[N]        preempt request, only effective with the matching req bit
//   num_in[N*W]      packed numbers, requester i at [i*W +: W]
//   dots_in[N*8]     packed dots, requester i at [i*8 +: 8]
//   dwell            show time in en ticks (0 behaves as 1)
//   pin              hold the current owner, dwell count frozen
//   num_out, dots_out  registered display data (zero unless showing)
//   grant[N]         one-hot current owner, zero in IDLE/BLANK
//   owner_idx        index of current/last owner
//   switch_pulse     one-clk pulse when grant becomes a new nonzero owner
//   state_dbg        current FSM state (0 IDLE, 1 SHOW, 2 BLANK)
module display_scheduler #(
  parameter int N           = 4,
  parameter int W           = 32,
  parameter int DWELL_W     = 8,
  parameter int BLANK_TICKS = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         urgent,
  input  logic [N*W-1:0]       num_in,
  input  logic [N*8-1:0]       dots_in,
  input  logic [DWELL_W-1:0]   dwell,
  input  logic                 pin,
  output logic [W-1:0]         num_out,
  output logic [7:0]           dots_out,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] owner_idx,
  output logic                 switch_pulse,
  output logic [1:0]           state_dbg
);

  localparam int IW = $clog2(N);
  localparam int BW = (BLANK_TICKS > 0) ? $clog2(BLANK_TICKS + 1) : 1;
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, BLANK = 2'd2} state_t;

  // What the FSM does on the next edge; decoded combinationally so the
  // sequential block is a flat apply-the-action case.
  typedef enum logic [2:0] {
    ACT_HOLD, ACT_TAKE, ACT_BLANK, ACT_IDLE, ACT_RELOAD, ACT_DEC, ACT_BDEC
  } act_t;

  state_t             state;
  act_t               act;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DWELL_W-1:0] dwell_eff;
  logic [BW-1:0]      blank_cnt;
  logic [IW-1:0]      win_idx;
  logic               win_valid;
  logic               win_urgent;
  logic [W-1:0]       num_arr  [N];
  logic [7:0]         dots_arr [N];
  int                 cand;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign num_arr[g]  = num_in[g*W +: W];
    assign dots_arr[g] = dots_in[g*8 +: 8];
  end

  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign state_dbg = state;

  // Winner: lowest urgent&req index; otherwise first req scanning upward
  // from owner_idx+1 (wrapping). The owner itself is the last candidate,
  // so winner==owner means nobody else is asking.
  always_comb begin
    win_valid  = 1'b0;
    win_urgent = 1'b0;
    win_idx    = '0;
    cand       = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (urgent[i] && req[i]) begin
        win_urgent = 1'b1;
        win_idx    = IW'(i);
      end
    end
    if (win_urgent) begin
      win_valid = 1'b1;
    end else begin
      // Descending offset so the nearest requester overrides farther ones.
      for (int k = N; k >= 1; k--) begin
        cand = int'(owner_idx) + k;
        if (cand >= N) cand = cand - N;
        if (req[cand[IW-1:0]]) begin
          win_valid = 1'b1;
          win_idx   = cand[IW-1:0];
        end
      end
    end
  end

  // Rule priority in SHOW: urgent switch, owner drop, pin, expiry, count.
  // Urgent is tested before owner drop so a simultaneous drop+urgent skips
  // the blank gap.
  always_comb begin
    act = ACT_HOLD;
    case (state)
      IDLE: begin
        if (win_valid) act = ACT_TAKE;
      end
      SHOW: begin
        if (win_urgent && (win_idx != owner_idx)) begin
          act = ACT_TAKE;
        end else if (!req[owner_idx]) begin
          if (BLANK_TICKS > 0)  act = ACT_BLANK;
          else if (win_valid)   act = ACT_TAKE;
          else                  act = ACT_IDLE;
        end else if (pin) begin
          act = ACT_HOLD;
        end else if (en) begin
          if (dwell_cnt > DWELL_W'(1))  act = ACT_DEC;
          else if (win_idx == owner_idx) act = ACT_RELOAD;
          else if (BLANK_TICKS > 0)      act = ACT_BLANK;
          else                           act = ACT_TAKE;
        end
      end
      BLANK: begin
        if (win_urgent) begin
          act = ACT_TAKE;
        end else if (en) begin
          if (blank_cnt > BW'(1)) act = ACT_BDEC;
          else if (win_valid)     act = ACT_TAKE;
          else                    act = ACT_IDLE;
        end
      end
      default: act = ACT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      owner_idx    <= IW'(N - 1);
      grant        <= '0;
      dwell_cnt    <= '0;
      blank_cnt    <= '0;
      switch_pulse <= 1'b0;
      num_out      <= '0;
      dots_out     <= '0;
    end else begin
      switch_pulse <= 1'b0;
      // Data follows the owner being shown this cycle, one clk behind.
      num_out  <= (state == SHOW) ? num_arr[owner_idx]  : '0;
      dots_out <= (state == SHOW) ? dots_arr[owner_idx] : '0;
      case (act)
        ACT_TAKE: begin
          state        <= SHOW;
          owner_idx    <= win_idx;
          grant        <= ONE << win_idx;
          dwell_cnt    <= dwell_eff;
          switch_pulse <= 1'b1;
        end
        ACT_BLANK: begin
          state     <= BLANK;
          grant     <= '0;
          blank_cnt <= BW'(BLANK_TICKS);
        end
        ACT_IDLE: begin
          state <= IDLE;
          grant <= '0;
        end
        ACT_RELOAD: dwell_cnt <= dwell_eff;
        ACT_DEC:    dwell_cnt <= dwell_cnt - DWELL_W'(1);
        ACT_BDEC:   blank_cnt <= blank_cnt - BW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Testbench for display_scheduler: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the
// scheduling rules.
module tb_display_scheduler;

  localparam int N       = 4;
  localparam int W       = 32;
  localparam int DWELL_W = 8;
  localparam int BT      = 2;
  localparam int M_IDLE  = 0;
  localparam int M_SHOW  = 1;
  localparam int M_BLANK = 2;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               en;
  logic [N-1:0]       req;
  logic [N-1:0]       urgent;
  logic [N*W-1:0]     num_in;
  logic [N*8-1:0]     dots_in;
  logic [DWELL_W-1:0] dwell;
  logic               pin;
  logic [W-1:0]       num_out;
  logic [7:0]         dots_out;
  logic [N-1:0]       grant;
  logic [1:0]         owner_idx;
  logic               switch_pulse;
  logic [1:0]         state_dbg;

  display_scheduler #(.N(N), .W(W), .DWELL_W(DWELL_W), .BLANK_TICKS(BT)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .req(req), .urgent(urgent),
    .num_in(num_in), .dots_in(dots_in), .dwell(dwell), .pin(pin),
    .num_out(num_out), .dots_out(dots_out), .grant(grant),
    .owner_idx(owner_idx), .switch_pulse(switch_pulse), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int en_div = 3;
  int phase = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  int         m_state;
  int         m_owner;
  int         m_dwell;
  int         m_blank;
  logic       m_pulse;
  logic [7:0] m_dots;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic bit_at(input logic [N-1:0] v, input int j);
    logic [N-1:0] t;
    t = v >> j;
    return t[0];
  endfunction

  // Returns the winning index or -1; urg reports an urgent win.
  function automatic int pick(output bit urg);
    urg = 1'b0;
    for (int i = 0; i < N; i++)
      if (bit_at(urgent, i) && bit_at(req, i)) begin
        urg = 1'b1;
        return i;
      end
    for (int k = 1; k <= N; k++)
      if (bit_at(req, (m_owner + k) % N)) return (m_owner + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_owner = N - 1;
    m_dwell = 0;
    m_blank = 0;
    m_pulse = 1'b0;
    m_dots  = 8'h00;
    exp_q.delete();
  endtask

  task automatic m_show(input int w);
    m_state = M_SHOW;
    m_owner = w;
    m_dwell = (dwell == 0) ? 1 : int'(dwell);
    m_pulse = 1'b1;
  endtask

  task automatic m_rearb(input int w);
    if (w >= 0) m_show(w);
    else m_state = M_IDLE;
  endtask

  // One clock of the scheduling rules, using the inputs seen at the edge.
  task automatic model_step();
    bit uw;
    int w;
    logic [N*W-1:0] tn;
    logic [N*8-1:0] td;
    tn = num_in >> (m_owner * W);
    td = dots_in >> (m_owner * 8);
    exp_q.push_back((m_state == M_SHOW) ? tn[W-1:0] : '0);
    m_dots  = (m_state == M_SHOW) ? td[7:0] : 8'h00;
    m_pulse = 1'b0;
    w = pick(uw);
    case (m_state)
      M_IDLE: if (w >= 0) m_show(w);
      M_SHOW: begin
        if (uw && w != m_owner) m_show(w);
        else if (!bit_at(req, m_owner)) begin
          m_state = M_BLANK;
          m_blank = BT;
        end else if (pin) begin
          // frozen
        end else if (en) begin
          m_dwell--;
          if (m_dwell == 0) begin
            if (w == m_owner) m_dwell = (dwell == 0) ? 1 : int'(dwell);
            else begin
              m_state = M_BLANK;
              m_blank = BT;
            end
          end
        end
      end
      default: begin
        if (uw) m_show(w);
        else if (en) begin
          m_blank--;
          if (m_blank == 0) m_rearb(w);
        end
      end
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic step();
    logic [W-1:0] exp_num;
    @(posedge clk);
    model_step();
    @(negedge clk);
    exp_num = exp_q.pop_front();
    if (switch_pulse) pulse_cnt++;
    check("grant", 64'(grant), 64'((m_state == M_SHOW) ? (1 << m_owner) : 0));
    check("owner_idx", 64'(owner_idx), 64'(m_owner));
    check("switch_pulse", 64'(switch_pulse), 64'(m_pulse));
    check("num_out", 64'(num_out), 64'(exp_num));
    check("dots_out", 64'(dots_out), 64'(m_dots));
    phase++;
    en = ((phase % en_div) == 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    reset_n = 1'b0;
    en      = 1'b0;
    req     = '0;
    urgent  = '0;
    pin     = 1'b0;
    dwell   = 8'd3;
    num_in  = '0;
    dots_in = '0;
    for (int i = 0; i < N; i++) begin
      num_in[i*W +: W]  = 32'hA000_0000 + 32'(i);
      dots_in[i*8 +: 8] = 8'h10 + 8'(i);
    end
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_owner", 64'(owner_idx), 64'(N - 1));
    check("rst_num", 64'(num_out), 64'(0));
    check("rst_dots", 64'(dots_out), 64'(0));
    check("rst_pulse", 64'(switch_pulse), 64'(0));
    reset_n = 1'b1;

    // Round robin between 0 and 2 with blank gaps.
    req = 4'b0101;
    dwell = 8'd3;
    step();
    check("first_rr_grant", 64'(grant), 64'(4'b0001));
    run(80);

    // Single requester: no blank, no extra pulses across expiries.
    req = 4'b0100;
    dwell = 8'd2;
    run(30);
    num_in[2*W +: W] = 32'h1234ABCD;
    step();
    check("num_latency", 64'(num_out), 64'(32'h1234ABCD));
    p0 = pulse_cnt;
    run(30);
    check("single_no_pulse", 64'(pulse_cnt - p0), 64'(0));

    // Urgent preemption mid-dwell.
    req = 4'b0001;
    dwell = 8'd3;
    run(30);
    req = 4'b1001;
    urgent = 4'b1000;
    step();
    check("urgent_grant", 64'(grant), 64'(4'b1000));
    urgent = 4'b0000;
    run(40);

    // Pin hold for 20 en ticks, then release.
    req = 4'b0011;
    run(14);
    pin = 1'b1;
    run(20 * en_div);
    pin = 1'b0;
    run(40);

    // Owner drops with no other request; dwell=0 acts as 1.
    req = 4'b0001;
    dwell = 8'd0;
    run(20);
    req = 4'b0000;
    run(16);
    check("idle_grant", 64'(grant), 64'(0));
    check("idle_num", 64'(num_out), 64'(0));

    // Asynchronous reset off a clock edge while showing.
    req = 4'b1111;
    dwell = 8'd3;
    run(10);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_grant", 64'(grant), 64'(0));
    check("async_num", 64'(num_out), 64'(0));
    check("async_dots", 64'(dots_out), 64'(0));
    check("async_owner", 64'(owner_idx), 64'(N - 1));
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("post_reset_grant", 64'(grant), 64'(4'b0001));
    run(20);

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 9) == 0)  req = N'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0)
        urgent = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 15)) : '0;
      if ($urandom_range(0, 29) == 0) pin = ~pin;
      if ($urandom_range(0, 49) == 0) dwell = DWELL_W'($urandom_range(0, 4));
      if ($urandom_range(0, 99) == 0) en_div = $urandom_range(1, 4);
      num_in  = {$urandom, $urandom, $urandom, $urandom};
      dots_in = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
